controlador_deslocamento: RTL and testbench

//  Timing and sequencing controller for the drone-simulator datapath.
//  - Generates the periodic map-scroll pulse (desloca_horizontal); period set by game mode.
//  - Arbitrates player move requests so move_drone never fires in the same cycle as a scroll.
//  - Filters collisions through an invulnerability window, emitting one-cycle colisao_valida.
//  - Sits between the game FSM and fluxo_dados.

---
 rtl/controlador_deslocamento.sv | 205 ++++++++++++++++++++
 tb/tb_controlador_deslocamento.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controlador_deslocamento.sv
// controlador_deslocamento: scroll timer, move arbiter and collision filter for the drone simulator.
// Optional build macro ACELERACAO_EN: scroll period shrinks by 1/8 every 16 scroll pulses.
module controlador_deslocamento #(
    parameter int PERIODO_BASE = 1000,
    parameter int INVULN_TICKS = 3,
    parameter int PERIODO_MIN  = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       pausa,
    input  logic [1:0] modo,
    input  logic       move_req,
    input  logic       colisao,
    input  logic       fim_mapa,
    output logic       desloca_horizontal,
    output logic       move_drone,
    output logic       colisao_valida,
    output logic       invulneravel,
    output logic       ativo,
    output logic [3:0] db_estado
);

    localparam int PMAX = (PERIODO_BASE > PERIODO_MIN) ? PERIODO_BASE : PERIODO_MIN;
    localparam int PW   = $clog2(PMAX + 1);
    localparam int IW   = $clog2(INVULN_TICKS + 1);

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        CARREGA = 3'd1,
        RODANDO = 3'd2,
        PAUSADO = 3'd3,
        FIM     = 3'd4
    } estado_t;

    estado_t       state_q, state_d;
    logic [PW-1:0] periodo_q, periodo_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] icnt_q, icnt_d;
    logic          pend_q, pend_d;
    logic          inv_q, inv_d;
    logic          desloca_q, desloca_d;
    logic          move_q, move_d;
    logic          colv_q, colv_d;
    logic          ativo_q, ativo_d;
    logic          rst_meta_q, rst_sync_q;
    logic          tick;
    logic          corre;
    logic          pedido;
    logic [PW-1:0] periodo_carga;

`ifdef ACELERACAO_EN
    logic [3:0]    acel_q, acel_d;
    logic [PW-1:0] periodo_acel;

    always_comb begin
        periodo_acel = periodo_q - (periodo_q >> 3);
        if (periodo_acel < PW'(PERIODO_MIN)) begin
            periodo_acel = PW'(PERIODO_MIN);
        end
    end
`endif

    // Reset asserts immediately but is released only on a clock edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            OCIOSO:  if (iniciar) state_d = CARREGA;
            CARREGA: state_d = RODANDO;
            RODANDO: begin
                if (iniciar)       state_d = CARREGA;
                else if (fim_mapa) state_d = FIM;
                else if (pausa)    state_d = PAUSADO;
            end
            PAUSADO: begin
                if (iniciar)       state_d = CARREGA;
                else if (!pausa)   state_d = RODANDO;
            end
            FIM:     if (iniciar) state_d = CARREGA;
            default: state_d = OCIOSO;
        endcase
    end

    assign periodo_carga = PW'(PERIODO_BASE >> modo);
    assign tick          = (cnt_q == periodo_q - PW'(1));
    assign corre         = (state_q == RODANDO) && (state_d == RODANDO);
    // A request arriving while the previous grant is still on the output is dropped.
    assign pedido        = pend_q | (move_req & ~move_q);

    always_comb begin
        periodo_d = periodo_q;
        cnt_d     = cnt_q;
        icnt_d    = icnt_q;
        pend_d    = pend_q;
        inv_d     = inv_q;
        desloca_d = 1'b0;
        move_d    = 1'b0;
        colv_d    = 1'b0;
        ativo_d   = (state_d == RODANDO) || (state_d == PAUSADO);
`ifdef ACELERACAO_EN
        acel_d    = acel_q;
`endif

        if (state_q == CARREGA) begin
            periodo_d = periodo_carga;
        end

        if ((state_d == CARREGA) || (state_d == OCIOSO) || (state_d == FIM)) begin
            cnt_d  = '0;
            icnt_d = '0;
            pend_d = 1'b0;
            inv_d  = 1'b0;
`ifdef ACELERACAO_EN
            acel_d = '0;
`endif
        end else if (corre) begin
            desloca_d = tick;
            cnt_d     = tick ? '0 : cnt_q + PW'(1);

            // A grant that would land on a scroll cycle is held one cycle.
            if (pedido) begin
                if (tick) begin
                    pend_d = 1'b1;
                end else begin
                    move_d = 1'b1;
                    pend_d = 1'b0;
                end
            end

            if (!inv_q && colisao) begin
                colv_d = 1'b1;
                inv_d  = 1'b1;
                icnt_d = IW'(INVULN_TICKS);
            end else if (inv_q) begin
                if (icnt_q == '0) begin
                    inv_d = 1'b0;
                end else if (tick) begin
                    icnt_d = icnt_q - IW'(1);
                end
            end

`ifdef ACELERACAO_EN
            // The shortened period takes effect on the wrap of the 16th pulse.
            if (tick) begin
                acel_d = acel_q + 4'd1;
                if (acel_q == 4'd15) begin
                    periodo_d = periodo_acel;
                end
            end
`endif
        end else if ((state_q == RODANDO) && (state_d == PAUSADO)) begin
            pend_d = pedido;
        end
    end

    always_ff @(posedge clock or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q   <= OCIOSO;
            periodo_q <= '0;
            cnt_q     <= '0;
            icnt_q    <= '0;
            pend_q    <= 1'b0;
            inv_q     <= 1'b0;
            desloca_q <= 1'b0;
            move_q    <= 1'b0;
            colv_q    <= 1'b0;
            ativo_q   <= 1'b0;
`ifdef ACELERACAO_EN
            acel_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            periodo_q <= periodo_d;
            cnt_q     <= cnt_d;
            icnt_q    <= icnt_d;
            pend_q    <= pend_d;
            inv_q     <= inv_d;
            desloca_q <= desloca_d;
            move_q    <= move_d;
            colv_q    <= colv_d;
            ativo_q   <= ativo_d;
`ifdef ACELERACAO_EN
            acel_q    <= acel_d;
`endif
        end
    end

    assign desloca_horizontal = desloca_q;
    assign move_drone         = move_q;
    assign colisao_valida     = colv_q;
    assign invulneravel       = inv_q;
    assign ativo              = ativo_q;
    assign db_estado          = {1'b0, state_q};

endmodule

// File: tb/tb_controlador_deslocamento.sv
// Self-checking bench for controlador_deslocamento with PERIODO_BASE=16, INVULN_TICKS=2.
// Expected pulse cycles are queued when stimulus is applied and popped as the DUT pulses.
module tb_controlador_deslocamento;

    logic       clock;
    logic       reset;
    logic       iniciar;
    logic       pausa;
    logic [1:0] modo;
    logic       move_req;
    logic       colisao;
    logic       fim_mapa;
    logic       desloca_horizontal;
    logic       move_drone;
    logic       colisao_valida;
    logic       invulneravel;
    logic       ativo;
    logic [3:0] db_estado;

    int cyc;
    int checks;
    int passed;
    int qDesloca[$];
    int qMove[$];
    int qColv[$];

    controlador_deslocamento #(
        .PERIODO_BASE(16),
        .INVULN_TICKS(2),
        .PERIODO_MIN (8)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .iniciar           (iniciar),
        .pausa             (pausa),
        .modo              (modo),
        .move_req          (move_req),
        .colisao           (colisao),
        .fim_mapa          (fim_mapa),
        .desloca_horizontal(desloca_horizontal),
        .move_drone        (move_drone),
        .colisao_valida    (colisao_valida),
        .invulneravel      (invulneravel),
        .ativo             (ativo),
        .db_estado         (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Each step ends 1 time unit after a rising edge: outputs are stable, inputs set here apply to this cycle.
    task automatic step;
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic startRun(input logic [1:0] m, output int entry);
        modo    = m;
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        step();
        entry = cyc;
    endtask

    task automatic test_reset;
        int e;
        startRun(2'd0, e);
        for (int k = 0; k < 5; k++) step();
        colisao = 1'b1;
        step();
        colisao = 1'b0;
        step();
        checks++;
        if ({ativo, invulneravel} !== 2'b11) $display("[TB] FAIL reset_prerun: got %b expected 11", {ativo, invulneravel});
        else passed++;
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({desloca_horizontal, move_drone, colisao_valida, invulneravel, ativo, db_estado} !== 9'd0)
            $display("[TB] FAIL reset_async: got %b expected 0", {desloca_horizontal, move_drone, colisao_valida, invulneravel, ativo, db_estado});
        else passed++;
        iniciar = 1'b1;
        step();
        step();
        checks++;
        if ({ativo, db_estado} !== 5'd0) $display("[TB] FAIL reset_held: got %b expected 0", {ativo, db_estado});
        else passed++;
        iniciar = 1'b0;
        reset   = 1'b1;
        for (int k = 0; k < 4; k++) step();
        checks++;
        if (db_estado !== 4'd0) $display("[TB] FAIL reset_release_idle: got %0d expected 0", db_estado);
        else passed++;
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        checks++;
        if (db_estado !== 4'd1) $display("[TB] FAIL reset_carrega: got %0d expected 1", db_estado);
        else passed++;
        step();
        checks++;
        if ({ativo, db_estado} !== 5'b1_0010) $display("[TB] FAIL reset_rodando: got %b expected 10010", {ativo, db_estado});
        else passed++;
    endtask

    task automatic test_scroll;
        int e;
        int exp;
        qDesloca.delete();
        startRun(2'd1, e);
        for (int n = 1; n <= 3; n++) qDesloca.push_back(e + 8 * n);
        for (int k = 1; k <= 26; k++) begin
            step();
            if (desloca_horizontal) begin
                checks++;
                if (qDesloca.size() == 0) $display("[TB] FAIL scroll_unexpected: got pulse at %0d expected none", cyc - e);
                else begin
                    exp = qDesloca.pop_front();
                    if (cyc !== exp) $display("[TB] FAIL scroll_time: got %0d expected %0d", cyc - e, exp - e);
                    else passed++;
                end
            end
        end
        checks++;
        if (qDesloca.size() != 0) $display("[TB] FAIL scroll_missing: got %0d pending expected 0", qDesloca.size());
        else passed++;
    endtask

    task automatic test_move;
        int e;
        int exp;
        qMove.delete();
        startRun(2'd1, e);
        qMove.push_back(e + 9);
        qMove.push_back(e + 12);
        for (int k = 1; k <= 22; k++) begin
            step();
            move_req = (k == 7) || (k == 11) || (k == 12);
            if (move_drone) begin
                checks++;
                if (desloca_horizontal !== 1'b0) $display("[TB] FAIL move_coincident: got scroll %b expected 0", desloca_horizontal);
                else passed++;
                checks++;
                if (qMove.size() == 0) $display("[TB] FAIL move_unexpected: got move at %0d expected none", cyc - e);
                else begin
                    exp = qMove.pop_front();
                    if (cyc !== exp) $display("[TB] FAIL move_time: got %0d expected %0d", cyc - e, exp - e);
                    else passed++;
                end
            end
        end
        move_req = 1'b0;
        checks++;
        if (qMove.size() != 0) $display("[TB] FAIL move_missing: got %0d pending expected 0", qMove.size());
        else passed++;
    endtask

    task automatic test_collision;
        int  e;
        int  exp;
        logic invExp;
        qColv.delete();
        startRun(2'd0, e);
        colisao = 1'b1;
        qColv.push_back(e + 1);
        qColv.push_back(e + 41);
        for (int k = 1; k <= 44; k++) begin
            step();
            colisao = (k <= 31) || (k == 40);
            invExp  = ((k >= 1) && (k <= 32)) || (k >= 41);
            checks++;
            if (invulneravel !== invExp) $display("[TB] FAIL invuln_window: got %b expected %b at %0d", invulneravel, invExp, k);
            else passed++;
            if (colisao_valida) begin
                checks++;
                if (qColv.size() == 0) $display("[TB] FAIL colv_unexpected: got pulse at %0d expected none", cyc - e);
                else begin
                    exp = qColv.pop_front();
                    if (cyc !== exp) $display("[TB] FAIL colv_time: got %0d expected %0d", cyc - e, exp - e);
                    else passed++;
                end
            end
        end
        colisao = 1'b0;
        checks++;
        if (qColv.size() != 0) $display("[TB] FAIL colv_missing: got %0d pending expected 0", qColv.size());
        else passed++;
    endtask

    task automatic test_pause;
        int e;
        int exp;
        qDesloca.delete();
        startRun(2'd0, e);
        qDesloca.push_back(e + 36 + 11);
        for (int k = 1; k <= 50; k++) begin
            step();
            pausa = (k >= 5) && (k <= 34);
            if (k == 20) begin
                checks++;
                if ({ativo, db_estado} !== 5'b1_0011) $display("[TB] FAIL pause_state: got %b expected 10011", {ativo, db_estado});
                else passed++;
            end
            if (k == 36) begin
                checks++;
                if (db_estado !== 4'd2) $display("[TB] FAIL pause_resume: got %0d expected 2", db_estado);
                else passed++;
            end
            if (desloca_horizontal) begin
                checks++;
                if (qDesloca.size() == 0) $display("[TB] FAIL pause_unexpected: got pulse at %0d expected none", cyc - e);
                else begin
                    exp = qDesloca.pop_front();
                    if (cyc !== exp) $display("[TB] FAIL pause_scroll_after_resume: got %0d expected %0d", cyc - e, exp - e);
                    else passed++;
                end
            end
        end
        pausa = 1'b0;
        checks++;
        if (qDesloca.size() != 0) $display("[TB] FAIL pause_missing: got %0d pending expected 0", qDesloca.size());
        else passed++;
    endtask

    task automatic test_fim;
        int e;
        startRun(2'd0, e);
        for (int k = 1; k <= 3; k++) step();
        fim_mapa = 1'b1;
        colisao  = 1'b1;
        step();
        fim_mapa = 1'b0;
        colisao  = 1'b0;
        checks++;
        if ({colisao_valida, invulneravel, ativo, db_estado} !== 7'b000_0100)
            $display("[TB] FAIL fim_state: got %b expected 0000100", {colisao_valida, invulneravel, ativo, db_estado});
        else passed++;
        move_req = 1'b1;
        step();
        move_req = 1'b0;
        checks++;
        if ({move_drone, colisao_valida, db_estado} !== 6'b00_0100)
            $display("[TB] FAIL fim_ignore: got %b expected 000100", {move_drone, colisao_valida, db_estado});
        else passed++;
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        checks++;
        if (db_estado !== 4'd1) $display("[TB] FAIL fim_restart_carrega: got %0d expected 1", db_estado);
        else passed++;
        step();
        checks++;
        if (db_estado !== 4'd2) $display("[TB] FAIL fim_restart_rodando: got %0d expected 2", db_estado);
        else passed++;
    endtask

`ifdef ACELERACAO_EN
    task automatic test_aceleracao;
        int e;
        int exp;
        qDesloca.delete();
        startRun(2'd0, e);
        for (int n = 1; n <= 16; n++) qDesloca.push_back(e + 16 * n);
        qDesloca.push_back(e + 256 + 14);
        qDesloca.push_back(e + 256 + 28);
        for (int k = 1; k <= 290; k++) begin
            step();
            if (desloca_horizontal) begin
                checks++;
                if (qDesloca.size() == 0) $display("[TB] FAIL acel_unexpected: got pulse at %0d expected none", cyc - e);
                else begin
                    exp = qDesloca.pop_front();
                    if (cyc !== exp) $display("[TB] FAIL acel_time: got %0d expected %0d", cyc - e, exp - e);
                    else passed++;
                end
            end
        end
        checks++;
        if (qDesloca.size() != 0) $display("[TB] FAIL acel_missing: got %0d pending expected 0", qDesloca.size());
        else passed++;
    endtask
`endif

    initial begin
        cyc      = 0;
        checks   = 0;
        passed   = 0;
        reset    = 1'b0;
        iniciar  = 1'b0;
        pausa    = 1'b0;
        modo     = 2'd0;
        move_req = 1'b0;
        colisao  = 1'b0;
        fim_mapa = 1'b0;
        for (int k = 0; k < 3; k++) step();
        checks++;
        if ({desloca_horizontal, move_drone, colisao_valida, invulneravel, ativo, db_estado} !== 9'd0)
            $display("[TB] FAIL power_on_reset: got %b expected 0", {desloca_horizontal, move_drone, colisao_valida, invulneravel, ativo, db_estado});
        else passed++;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) step();

        test_reset();
        test_scroll();
        test_move();
        test_collision();
        test_pause();
        test_fim();
`ifdef ACELERACAO_EN
        test_aceleracao();
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
